// File: rtl/vending_machine_param.sv
// Parametrised coin-operated vending controller: credit accumulation, vend,
// greedy 10/5 rs change or refund streaming, coin rejection and stock tracking.
module vending_machine_param #(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 8,
    parameter int CREDIT_W   = 4,
    parameter int STOCK_INIT = 8,
    parameter int STOCK_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          in,
    input  logic                cancel,
    input  logic                restock,
    output logic                bottle,
    output logic [1:0]          change,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                sold_out
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    localparam logic [1:0]          CHG_NONE = 2'b00;
    localparam logic [1:0]          CHG_5    = 2'b01;
    localparam logic [1:0]          CHG_10   = 2'b10;
    localparam logic [CREDIT_W:0]   PRICE_X  = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_X    = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0]  STOCK_LD = STOCK_W'(STOCK_INIT);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   remaining_q, remaining_d;
    logic [STOCK_W-1:0]    stock_q, stock_d;
    logic                  bottle_q, bottle_d;
    logic [1:0]            change_q, change_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  sold_out_q, sold_out_d;

    logic                  coin_present;
    logic [CREDIT_W:0]     coin_val;
    logic [CREDIT_W:0]     sum;

    function automatic logic [1:0] pick_coin(input logic [CREDIT_W-1:0] amt);
        return (amt >= CREDIT_W'(2)) ? CHG_10 : CHG_5;
    endfunction

    function automatic logic [CREDIT_W-1:0] after_coin(input logic [CREDIT_W-1:0] amt);
        return (amt >= CREDIT_W'(2)) ? amt - CREDIT_W'(2) : amt - CREDIT_W'(1);
    endfunction

    always_comb begin
        coin_present = (in != 2'b00);
        case (in)
            2'b01:   coin_val = (CREDIT_W+1)'(1);
            2'b10:   coin_val = (CREDIT_W+1)'(2);
            2'b11:   coin_val = (CREDIT_W+1)'(4);
            default: coin_val = '0;
        endcase
        sum = {1'b0, credit_q} + coin_val;
    end

    // The first change coin is issued on the same edge that enters CHANGE, so
    // CHANGE holds exactly while a coin is on the change output.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        remaining_d   = remaining_q;
        stock_d       = stock_q;
        bottle_d      = 1'b0;
        change_d      = CHG_NONE;
        coin_reject_d = 1'b0;

        case (state_q)
            COLLECT: begin
                if (cancel) begin
                    coin_reject_d = coin_present;
                    if (credit_q != '0) begin
                        change_d    = pick_coin(credit_q);
                        remaining_d = after_coin(credit_q);
                        credit_d    = '0;
                        state_d     = CHANGE;
                    end
                end else if (coin_present) begin
                    if (sold_out_q || (sum > MAX_X)) begin
                        coin_reject_d = 1'b1;
                    end else if (sum >= PRICE_X) begin
                        remaining_d = CREDIT_W'(sum - PRICE_X);
                        credit_d    = '0;
                        bottle_d    = 1'b1;
                        state_d     = VEND;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_present;
                stock_d       = stock_q - STOCK_W'(1);
                if (remaining_q != '0) begin
                    change_d    = pick_coin(remaining_q);
                    remaining_d = after_coin(remaining_q);
                    state_d     = CHANGE;
                end else begin
                    state_d = COLLECT;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_present;
                if (remaining_q != '0) begin
                    change_d    = pick_coin(remaining_q);
                    remaining_d = after_coin(remaining_q);
                end else begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (restock) begin
            stock_d = STOCK_LD;
        end
        sold_out_d = (stock_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= COLLECT;
            credit_q      <= '0;
            remaining_q   <= '0;
            stock_q       <= STOCK_LD;
            bottle_q      <= 1'b0;
            change_q      <= CHG_NONE;
            coin_reject_q <= 1'b0;
            sold_out_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            remaining_q   <= remaining_d;
            stock_q       <= stock_d;
            bottle_q      <= bottle_d;
            change_q      <= change_d;
            coin_reject_q <= coin_reject_d;
            sold_out_q    <= sold_out_d;
        end
    end

    assign bottle      = bottle_q;
    assign change      = change_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign sold_out    = sold_out_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a queue-of-output-events model of the vending rules.
module tb_vending_machine_param;

    localparam int PRICE      = 4;
    localparam int MAX_CREDIT = 8;
    localparam int CREDIT_W   = 4;
    localparam int STOCK_INIT = 2;
    localparam int STOCK_W    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0]          in;
    logic                cancel;
    logic                restock;
    logic                bottle;
    logic [1:0]          change;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                sold_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: cur is what the outputs show this cycle (0 idle, 4 bottle,
    // 1/2 a 5/10 rs coin); pend holds the output cycles still to come.
    int pend[$];
    int cur;
    int m_credit;
    int m_stock;
    int m_rej;
    int m_sold;

    always #5 clk = ~clk;

    vending_machine_param #(
        .PRICE     (PRICE),
        .MAX_CREDIT(MAX_CREDIT),
        .CREDIT_W  (CREDIT_W),
        .STOCK_INIT(STOCK_INIT),
        .STOCK_W   (STOCK_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .cancel     (cancel),
        .restock    (restock),
        .bottle     (bottle),
        .change     (change),
        .coin_reject(coin_reject),
        .credit     (credit),
        .sold_out   (sold_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_change(input int amount);
        int n = amount;
        while (n >= 2) begin
            pend.push_back(2);
            n -= 2;
        end
        if (n == 1) pend.push_back(1);
    endtask

    task automatic model_edge(input logic r, input logic [1:0] c, input logic cn, input logic rs);
        int v;
        int busy;
        v = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 4 : 0;
        if (!r) begin
            pend.delete();
            cur = 0; m_credit = 0; m_stock = STOCK_INIT; m_rej = 0; m_sold = 0;
        end else begin
            busy  = (cur != 0);
            m_rej = 0;
            if (busy) begin
                m_rej = (v != 0);
            end else if (cn) begin
                m_rej = (v != 0);
                if (m_credit > 0) begin
                    push_change(m_credit);
                    m_credit = 0;
                end
            end else if (v != 0) begin
                if (m_sold != 0 || m_credit + v > MAX_CREDIT) begin
                    m_rej = 1;
                end else if (m_credit + v >= PRICE) begin
                    pend.push_back(4);
                    push_change(m_credit + v - PRICE);
                    m_credit = 0;
                end else begin
                    m_credit += v;
                end
            end
            if (cur == 4) m_stock--;
            if (rs) m_stock = STOCK_INIT;
            cur    = (pend.size() > 0) ? pend.pop_front() : 0;
            m_sold = (m_stock == 0);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic cn, input logic rs);
        @(negedge clk);
        reset = r; in = c; cancel = cn; restock = rs;
        @(posedge clk);
        model_edge(r, c, cn, rs);
        #1;
        check("bottle",      32'(bottle),      32'(cur == 4));
        check("change",      32'(change),      32'((cur == 4) ? 0 : cur));
        check("coin_reject", 32'(coin_reject), 32'(m_rej));
        check("credit",      32'(credit),      32'(m_credit));
        check("sold_out",    32'(sold_out),    32'(m_sold));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; in = 2'b00; cancel = 1'b0; restock = 1'b0;
        cur = 0; m_credit = 0; m_stock = STOCK_INIT; m_rej = 0; m_sold = 0;

        step(1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        check("reset_credit", 32'(credit), 32'd0);
        check("reset_change", 32'(change), 32'd0);

        // 5 + 5 + 10: exact price, no change
        step(1'b1, 2'b01, 1'b0, 1'b0);
        check("credit_after_5", 32'(credit), 32'd1);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        check("vend_exact", 32'(bottle), 32'd1);
        idle(2);

        // 10 + 20: one 10 rs change coin, depletes stock
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        idle(3);
        check("sold_out_set", 32'(sold_out), 32'd1);

        // sold out rejects, restock re-enables
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        check("credit_after_restock", 32'(credit), 32'd1);

        // credit 3 + 20: change 10 then 5
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        idle(4);

        // credit 3 then cancel with a coin: refund 10 then 5, coin rejected
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b1, 1'b0);
        check("cancel_reject", 32'(coin_reject), 32'd1);
        idle(3);

        // coins during VEND and CHANGE are rejected
        step(1'b1, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0);
        idle(3);

        // restock coincident with the VEND decrement
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b1);
        idle(2);

        // reset in the middle of a refund
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        check("reset_mid_change", 32'(change), 32'd0);
        idle(2);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) != 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
